// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit with HI/LO: shift-add multiplier, restoring divider, sign fix-up state.
// Optional MULDIV_EARLY_TERM_EN: multiply exits once the remaining multiplier bits are all zero.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             r_state;
    logic               r_busy;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_prod, r_mcand;
    logic [WIDTH-1:0]   r_mplier, r_rem, r_quo, r_dvs, r_a_raw, r_hi, r_lo;
    logic               r_is_mul, r_neg_q, r_neg_r, r_dz;

    logic               w_signed, w_a_neg, w_b_neg, w_last, w_mul_done, w_div_ge;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_div_sub, w_quo_fix, w_rem_fix;
    logic [WIDTH:0]     w_div_sh;
    logic [2*WIDTH-1:0] w_prod_fix;

    // Signed ops latch magnitudes; 0x80000000 negates to itself and is read as unsigned.
    assign w_signed  = op_code[1];
    assign w_a_neg   = w_signed && op_a[WIDTH-1];
    assign w_b_neg   = w_signed && op_b[WIDTH-1];
    assign w_a_mag   = w_a_neg ? -op_a : op_a;
    assign w_b_mag   = w_b_neg ? -op_b : op_b;

    assign w_last    = (r_cnt == CW'(WIDTH-1));
`ifdef MULDIV_EARLY_TERM_EN
    assign w_mul_done = w_last || (r_mplier[WIDTH-1:1] == '0);
`else
    assign w_mul_done = w_last;
`endif

    // Partial remainder is always below the divisor, so the difference fits in WIDTH bits.
    assign w_div_sh  = {r_rem, r_quo[WIDTH-1]};
    assign w_div_ge  = (w_div_sh >= {1'b0, r_dvs});
    assign w_div_sub = w_div_sh[WIDTH-1:0] - r_dvs;

    assign w_prod_fix = r_neg_q ? -r_prod : r_prod;
    assign w_quo_fix  = r_neg_q ? -r_quo  : r_quo;
    assign w_rem_fix  = r_neg_r ? -r_rem  : r_rem;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_a_raw  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_mul <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        case (op_code)
                            3'b100: r_hi <= op_a;
                            3'b101: r_lo <= op_a;
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                r_cnt    <= '0;
                                r_a_raw  <= op_a;
                                r_prod   <= '0;
                                r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                                r_mplier <= w_b_mag;
                                r_rem    <= '0;
                                r_quo    <= w_a_mag;
                                r_dvs    <= w_b_mag;
                                r_neg_q  <= w_a_neg ^ w_b_neg;
                                r_neg_r  <= w_a_neg;
                                r_is_mul <= op_code[0];
                                r_dz     <= (op_b == '0);
                                r_busy   <= 1'b1;
                                if (op_code[0])
                                    r_state <= S_MUL;
                                else if (op_b == '0)
                                    r_state <= S_FIX;
                                else
                                    r_state <= S_DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (r_mplier[0])
                        r_prod <= r_prod + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_mul_done)
                        r_state <= S_FIX;
                end
                S_DIV: begin
                    r_quo <= {r_quo[WIDTH-2:0], w_div_ge};
                    r_rem <= w_div_ge ? w_div_sub : w_div_sh[WIDTH-1:0];
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last)
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_is_mul) begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end else if (r_dz) begin
                        r_hi <= r_a_raw;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign stall    = reset_n && op_valid && r_busy;
    assign rd_valid = reset_n && op_valid && !r_busy && (op_code[2:1] == 2'b11);
    assign rd_data  = rd_valid ? (op_code[0] ? r_lo : r_hi) : '0;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer against an arithmetic reference model of HI/LO and busy length.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = 3'b000;
    logic [31:0] op_a = '0, op_b = '0;
    logic        busy, stall, rd_valid;
    logic [31:0] rd_data, hi, lo;

    logic [31:0] m_hi = '0, m_lo = '0;
    int          n_chk = 0, n_pass = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_code(op_code),
        .op_a(op_a), .op_b(op_b), .busy(busy), .stall(stall),
        .rd_data(rd_data), .rd_valid(rd_valid), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic int exp_busy(input logic [2:0] code, input logic [31:0] b);
        logic [31:0] mag;
        int p;
        if (!code[0] && b == 0) return 1;
        mag = (code[1] && b[31]) ? -b : b;
        p = -1;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
`ifdef MULDIV_EARLY_TERM_EN
        if (code[0]) return ((p + 1 > 1) ? p + 1 : 1) + 1;
`endif
        return 33;
    endfunction

    task automatic ref_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] eh, output logic [31:0] el);
        longint      sa, sb;
        logic [63:0] r64, q64;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (code[0]) begin
            if (code[1]) r64 = sa * sb;
            else         r64 = {32'b0, a} * {32'b0, b};
            eh = r64[63:32];
            el = r64[31:0];
        end else if (b == 0) begin
            eh = a;
            el = 32'hFFFFFFFF;
        end else if (code[1]) begin
            q64 = sa / sb;
            r64 = sa % sb;
            el = q64[31:0];
            eh = r64[31:0];
        end else begin
            el = a / b;
            eh = a % b;
        end
    endtask

    task automatic run_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b, input bit hold_mf);
        logic [31:0] eh, el, oh, ol;
        int n, eb;
        @(negedge clk);
        op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
        if (code[2]) begin
            #1;
            chk("stall_idle", stall, 1'b0);
            if (code[1]) begin
                chk("rd_valid", rd_valid, 1'b1);
                chk("rd_data", rd_data, code[0] ? m_lo : m_hi);
            end else begin
                chk("rd_valid_mt", rd_valid, 1'b0);
            end
            @(posedge clk); #1;
            op_valid = 1'b0;
            if (code[1:0] == 2'b00) m_hi = a;
            if (code[1:0] == 2'b01) m_lo = a;
            chk("busy_single", busy, 1'b0);
            chk("hi_after", hi, m_hi);
            chk("lo_after", lo, m_lo);
            return;
        end
        ref_op(code, a, b, eh, el);
        eb = exp_busy(code, b);
        oh = m_hi; ol = m_lo;
        @(posedge clk); #1;
        if (hold_mf) op_code = 3'b110;
        else op_valid = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (hold_mf) chk("stall_busy", stall, 1'b1);
            if (n == 1) chk("hold_hilo", {hi, lo}, {oh, ol});
            @(posedge clk); #1;
        end
        chk("busy_len", n, eb);
        m_hi = eh; m_lo = el;
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        if (hold_mf) begin
            chk("rd_valid_after", rd_valid, 1'b1);
            chk("rd_data_after", rd_data, m_hi);
            op_valid = 1'b0;
        end
    endtask

    initial begin
        logic [2:0]  c;
        logic [31:0] a, b;
        int n;
        op_valid = 1'b1; op_code = 3'b110;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_hilo", {hi, lo}, 64'h0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_stall", stall, 1'b0);
        op_valid = 1'b0;
        @(negedge clk); reset_n = 1'b1;

        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(3'b011, 32'hFFFFFFFD, 32'd7, 1'b1);
        run_op(3'b010, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_op(3'b000, 32'd100, 32'd7, 1'b0);
        run_op(3'b000, 32'h1234, 32'd0, 1'b0);
        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op(3'b010, 32'hFFFFFF00, 32'd0, 1'b1);
        run_op(3'b100, 32'hA5A5A5A5, 32'd0, 1'b0);
        run_op(3'b110, 32'd0, 32'd0, 1'b0);
        run_op(3'b101, 32'h5A5A0F0F, 32'd0, 1'b0);
        run_op(3'b111, 32'd0, 32'd0, 1'b0);
        run_op(3'b001, 32'd5, 32'd1, 1'b0);
        run_op(3'b001, 32'd5, 32'd0, 1'b0);
        run_op(3'b001, 32'd5, 32'h80000000, 1'b0);
        run_op(3'b011, 32'h80000000, 32'h80000000, 1'b0);

        for (int i = 0; i < 40; i++) begin
            c = 3'($urandom_range(0, 7));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 300));
                2: b = -32'($urandom_range(1, 300));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            run_op(c, a, b, bit'($urandom_range(0, 1)));
        end

        // Abort a multiply partway through with reset.
        @(negedge clk);
        op_valid = 1'b1; op_code = 3'b011; op_a = 32'h12345678; op_b = 32'hFFFF0001;
        @(posedge clk); #1;
        op_code = 3'b110;
        n = 0;
        while (busy && n < 10) begin
            n++;
            if (n < 10) begin @(posedge clk); #1; end
        end
        chk("busy_at_10", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_hilo", {hi, lo}, 64'h0);
        chk("abort_stall", stall, 1'b0);
        chk("abort_rd_valid", rd_valid, 1'b0);
        op_valid = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        run_op(3'b001, 32'd9, 32'd6, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
